// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg
// Shared definitions for the CPU clock controller: the mode state encoding
// and the width of the mode port.
package cpu_clk_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_RUN  = 2'd0,
      MODE_STEP = 2'd1,
      MODE_HALT = 2'd2
   } mode_e;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Turns a raw push-button level into a one-cycle pulse per press: 2-flop
// synchroniser, optional debouncer, rising-edge detector.
// Optional feature macro: CPU_CLOCK_CTRL_DEBOUNCE_EN (adds the debouncer).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_key,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic w_level;

   // Bring the asynchronous button level into the clock domain
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
      end
   end

`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_level;
   logic [CNT_W-1:0] r_stableCnt;

   // Adopt a new level only after it has differed from the current one for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge clk) begin
      if (reset) begin
         r_level     <= 1'b0;
         r_stableCnt <= '0;
      end else if (r_sync2 == r_level) begin
         r_stableCnt <= '0;
      end else if (r_stableCnt == CNT_LAST) begin
         r_level     <= r_sync2;
         r_stableCnt <= '0;
      end else begin
         r_stableCnt <= r_stableCnt + 1'b1;
      end
   end

   assign w_level = r_level;
`else
   assign w_level = r_sync2;
`endif

   // Remember the previous level so a held key yields exactly one pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_level;
      end
   end

   assign o_pulse = w_level & ~r_prev;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
// Clock-enable generator for the 8-bit CPU: RUN at four rates, STEP from a
// push-button, and HALT when the CPU executes HLT. The CPU runs on the board
// clock qualified by cpu_ce.
// Optional feature macro: CPU_CLOCK_CTRL_DEBOUNCE_EN (debounces both keys).
module cpu_clock_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int DIV_W           = 19,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step_key,
   input  logic              mode_key,
   input  logic [1:0]        rate_sel,
   input  logic              cpu_halt,
   output logic              cpu_ce,
   output logic [MODE_W-1:0] mode,
   output logic              tick_led
);

   logic             w_stepPulse;
   logic             w_modePulse;
   logic [DIV_W-1:0] w_termCount;
   logic             w_rateChange;
   logic             w_terminal;

   mode_e            r_state;
   logic [DIV_W-1:0] r_divCnt;
   logic [1:0]       r_rateSel;
   logic             r_ce;
   logic             r_tick;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stepKey (
      .clk     (clk),
      .reset   (reset),
      .i_key   (step_key),
      .o_pulse (w_stepPulse)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_modeKey (
      .clk     (clk),
      .reset   (reset),
      .i_key   (mode_key),
      .o_pulse (w_modePulse)
   );

   // Period is 2^(DIV_W - 2*rate), so the terminal count is all ones shifted right by 2*rate
   assign w_termCount  = {DIV_W{1'b1}} >> {r_rateSel, 1'b0};
   assign w_rateChange = (rate_sel != r_rateSel);
   assign w_terminal   = (r_divCnt == w_termCount);

   // Registered copy of the rate select so that a change restarts the period
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rateSel <= 2'd0;
      end else begin
         r_rateSel <= rate_sel;
      end
   end

   // Mode FSM, divider and cpu_ce generation; priority is halt, then mode pulse, then step/terminal count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= MODE_RUN;
         r_divCnt <= '0;
         r_ce     <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         r_ce     <= 1'b0;
         r_divCnt <= '0;
         case (r_state)
            MODE_RUN: begin
               if (cpu_halt) begin
                  r_state <= MODE_HALT;
               end else if (w_modePulse) begin
                  r_state <= MODE_STEP;
               end else if (!w_rateChange) begin
                  if (w_terminal) begin
                     r_ce   <= 1'b1;
                     r_tick <= ~r_tick;
                  end else begin
                     r_divCnt <= r_divCnt + 1'b1;
                  end
               end
            end
            MODE_STEP: begin
               if (cpu_halt) begin
                  r_state <= MODE_HALT;
               end else if (w_modePulse) begin
                  r_state <= MODE_RUN;
               end else if (w_stepPulse) begin
                  r_ce   <= 1'b1;
                  r_tick <= ~r_tick;
               end
            end
            MODE_HALT: begin
               if (!cpu_halt && w_modePulse) begin
                  r_state <= MODE_STEP;
               end
            end
            default: begin
               r_state <= MODE_RUN;
            end
         endcase
      end
   end

   assign cpu_ce   = r_ce;
   assign mode     = r_state;
   assign tick_led = r_tick;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl
// Directed-plus-random bench for cpu_clock_ctrl with DIV_W=8, DEBOUNCE_CYCLES=4.
// Expected cpu_ce pulse times are computed arithmetically (change time plus
// multiples of the period, press time plus key latency) and compared with the
// observed pulse times. Honours CPU_CLOCK_CTRL_DEBOUNCE_EN for key latency.
module tb_cpu_clock_ctrl;

   localparam int DivW           = 8;
   localparam int DebounceCycles = 4;
`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
   localparam int KeyLat = 3 + DebounceCycles;
`else
   localparam int KeyLat = 3;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       stepKey;
   logic       modeKey;
   logic [1:0] rateSel;
   logic       cpuHalt;
   logic       cpuCe;
   logic [1:0] mode;
   logic       tickLed;

   int   vectorCount = 0;
   int   failCount   = 0;
   int   tickCount   = 0;
   int   obsQ[$];
   int   expQ[$];
   logic expTick;
   int   curRate;
   logic curHalt;

   cpu_clock_ctrl #(
      .DIV_W           (DivW),
      .DEBOUNCE_CYCLES (DebounceCycles)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .step_key (stepKey),
      .mode_key (modeKey),
      .rate_sel (rateSel),
      .cpu_halt (cpuHalt),
      .cpu_ce   (cpuCe),
      .mode     (mode),
      .tick_led (tickLed)
   );

   // Free-running board clock
   always #5 clk = ~clk;

   // Hard bound on run time in case the sequence ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic s, input logic m, input logic [1:0] r, input logic h);
      stepKey = s;
      modeKey = m;
      rateSel = r;
      cpuHalt = h;
   endtask

   task automatic runTicks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         tickCount++;
         if (cpuCe === 1'b1) obsQ.push_back(tickCount);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic expectPulse(input int t);
      expQ.push_back(t);
      expTick = ~expTick;
   endtask

   task automatic comparePulses(input string tag);
      checkOutput({tag, " pulse count"}, obsQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
         checkOutput({tag, " pulse time"}, obsQ[i], expQ[i]);
      checkOutput({tag, " tick_led"}, {31'b0, tickLed}, {31'b0, expTick});
      obsQ.delete();
      expQ.delete();
   endtask

   task automatic pressKeys(input logic s, input logic m, input int hold);
      applyStimulus(s, m, 2'(curRate), curHalt);
      runTicks(hold);
      applyStimulus(1'b0, 1'b0, 2'(curRate), curHalt);
   endtask

   task automatic changeRate(input int r, input int window, input string tag);
      int p;
      int base;
      p       = 1 << (DivW - 2 * r);
      base    = tickCount;
      curRate = r;
      applyStimulus(1'b0, 1'b0, 2'(r), curHalt);
      for (int t = base + 1 + p; t <= base + window; t += p) expectPulse(t);
      runTicks(window);
      comparePulses(tag);
   endtask

   initial begin
      int base;
      int r;
      int w;
      int hold;
      int gap;
      int c;

      curRate = 0;
      curHalt = 1'b0;
      expTick = 1'b0;
      reset   = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
      runTicks(3);
      checkOutput("reset cpu_ce", {31'b0, cpuCe}, 0);
      checkOutput("reset mode", {30'b0, mode}, 0);
      checkOutput("reset tick_led", {31'b0, tickLed}, 0);
      obsQ.delete();

      $display("[TB] run mode at rate 0 after reset release");
      reset = 1'b0;
      base  = tickCount;
      for (int k = 1; k <= 3; k++) expectPulse(base + 256 * k);
      runTicks(800);
      comparePulses("rate0");

      changeRate(3, 40, "rate3");

      $display("[TB] random rate changes");
      for (int i = 0; i < 6; i++) begin
         do r = int'($urandom_range(0, 3)); while (r == curRate);
         w = int'($urandom_range(20, 300));
         changeRate(r, w, "random rate");
      end

      $display("[TB] enter step mode");
      if (curRate == 0) changeRate(1, 2, "pre clear");
      changeRate(0, 2, "clear");
      pressKeys(1'b0, 1'b1, 10);
      runTicks(10);
      checkOutput("enter step mode", {30'b0, mode}, 1);
      comparePulses("enter step");

      $display("[TB] random step presses");
      for (int i = 0; i < 5; i++) begin
         hold = (i == 0) ? 20 : int'($urandom_range(8, 20));
         gap  = int'($urandom_range(10, 20));
         expectPulse(tickCount + KeyLat);
         pressKeys(1'b1, 1'b0, hold);
         runTicks(gap);
      end
      comparePulses("step");

      $display("[TB] bouncing step key");
      base = tickCount;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 2'(curRate), curHalt);
         runTicks(2);
         applyStimulus(1'b0, 1'b0, 2'(curRate), curHalt);
         runTicks(2);
      end
      runTicks(20);
`ifndef CPU_CLOCK_CTRL_DEBOUNCE_EN
      for (int i = 0; i < 3; i++) expectPulse(base + 4 * i + KeyLat);
`endif
      comparePulses("bounce");

      $display("[TB] halt on terminal count");
      pressKeys(1'b0, 1'b1, 10);
      runTicks(5);
      checkOutput("back to run", {30'b0, mode}, 0);
      comparePulses("to run");
      base    = tickCount;
      curRate = 3;
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0);
      runTicks(4);
      curHalt = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b1);
      runTicks(1);
      checkOutput("halt mode", {30'b0, mode}, 2);
      checkOutput("halt cpu_ce", {31'b0, cpuCe}, 0);
      runTicks(10);
      pressKeys(1'b1, 1'b0, 10);
      runTicks(15);
      checkOutput("halt ignores step", {30'b0, mode}, 2);
      comparePulses("halt");
      curHalt = 1'b0;
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0);
      runTicks(3);
      checkOutput("halt persists", {30'b0, mode}, 2);
      pressKeys(1'b0, 1'b1, 10);
      runTicks(10);
      checkOutput("halt exit to step", {30'b0, mode}, 1);
      comparePulses("halt exit");

      $display("[TB] mode and step pulses coincide");
      applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
      runTicks(KeyLat - 1);
      checkOutput("collide before", {30'b0, mode}, 1);
      runTicks(1);
      c = tickCount;
      checkOutput("collide mode", {30'b0, mode}, 0);
      checkOutput("collide cpu_ce", {31'b0, cpuCe}, 0);
      runTicks(10 - KeyLat);
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0);
      runTicks(20);
      for (int t = c + 4; t <= tickCount; t += 4) expectPulse(t);
      comparePulses("collide run");

      $display("[TB] reset mid-run");
      curRate = 0;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
      runTicks(101);
      comparePulses("pre reset");
      reset = 1'b1;
      runTicks(1);
      expTick = 1'b0;
      checkOutput("midrun reset cpu_ce", {31'b0, cpuCe}, 0);
      checkOutput("midrun reset mode", {30'b0, mode}, 0);
      checkOutput("midrun reset tick_led", {31'b0, tickLed}, 0);
      obsQ.delete();
      reset = 1'b0;
      expectPulse(tickCount + 256);
      runTicks(300);
      comparePulses("after reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule
